// File: rtl/vend_pkg.sv
// Shared definitions for the vending sequencer: calculator op codes, register map,
// coin encodings/values, FSM states and the greedy change-coin picker.
package vend_pkg;

    typedef enum logic [2:0] {
        OP_CLR  = 3'd0,
        OP_ADDI = 3'd1,
        OP_SUBI = 3'd2,
        OP_SUB  = 3'd3
    } op_e;

    localparam logic [3:0] REG_ZERO   = 4'd0;
    localparam logic [3:0] REG_CREDIT = 4'd4;
    localparam logic [3:0] REG_SINK   = 4'd15;

    localparam logic [1:0] COIN_NICKEL  = 2'b00;
    localparam logic [1:0] COIN_DIME    = 2'b01;
    localparam logic [1:0] COIN_QUARTER = 2'b10;
    localparam logic [1:0] COIN_INVALID = 2'b11;

    localparam logic [3:0] VAL_NICKEL  = 4'd1;
    localparam logic [3:0] VAL_DIME    = 4'd2;
    localparam logic [3:0] VAL_QUARTER = 4'd5;

    typedef enum logic [3:0] {
        ST_INIT0   = 4'd0,
        ST_INIT1   = 4'd1,
        ST_IDLE    = 4'd2,
        ST_COIN    = 4'd3,
        ST_SEL_CHK = 4'd4,
        ST_DEBIT   = 4'd5,
        ST_VEND    = 4'd6,
        ST_DENY    = 4'd7,
        ST_CHANGE  = 4'd8
    } state_e;

    typedef struct packed {
        logic       vld;
        logic [1:0] coin;
        logic [3:0] amt;
    } change_t;

    function automatic logic [3:0] coin_value(input logic [1:0] t);
        logic [3:0] v;
        case (t)
            COIN_NICKEL:  v = VAL_NICKEL;
            COIN_DIME:    v = VAL_DIME;
            COIN_QUARTER: v = VAL_QUARTER;
            default:      v = 4'd0;
        endcase
        return v;
    endfunction

    // Largest coin not exceeding the remaining credit; vld=0 once credit is exhausted.
    function automatic change_t change_pick(input logic [9:0] credit);
        change_t c;
        c.vld  = 1'b1;
        c.coin = COIN_NICKEL;
        c.amt  = VAL_NICKEL;
        if (credit >= 10'(VAL_QUARTER)) begin
            c.coin = COIN_QUARTER;
            c.amt  = VAL_QUARTER;
        end else if (credit >= 10'(VAL_DIME)) begin
            c.coin = COIN_DIME;
            c.amt  = VAL_DIME;
        end else if (credit == 10'd0) begin
            c.vld  = 1'b0;
            c.amt  = 4'd0;
        end
        return c;
    endfunction

endpackage

// File: rtl/vend_sequencer.sv
// Sequences the credit calculator: coin/select/refund events become one-cycle micro-ops.
// Latency: coin 2, vend 4, deny 3, refund N+2 cycles to IDLE; events arriving while busy are dropped.
module vend_sequencer
    import vend_pkg::*;
#(
    parameter int MAX_CREDIT = 200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       coin_valid,
    input  logic [1:0] coin_type,
    input  logic       select_valid,
    input  logic [3:0] price,
    input  logic       refund_req,
    input  logic [9:0] paid,
    output logic [2:0] op,
    output logic [3:0] rw,
    output logic [3:0] ra,
    output logic [3:0] rb,
    output logic [3:0] imm4,
    output logic       busy,
    output logic       vend,
    output logic       deny,
    output logic       coin_reject,
    output logic       change_valid,
    output logic [1:0] change_type
);

    state_e      state_q, state_d;
    logic [3:0]  price_q, price_d;
    logic [3:0]  value_q, value_d;
    logic        reject_q, reject_d;
    logic [10:0] coin_sum;
    logic        coin_bad;
    change_t     chg;

    assign coin_sum = {1'b0, paid} + {7'd0, coin_value(coin_type)};
    assign coin_bad = (coin_type == COIN_INVALID) || (coin_sum > 11'(MAX_CREDIT));
    assign chg      = change_pick(paid);

    always_comb begin
        state_d  = state_q;
        price_d  = price_q;
        value_d  = value_q;
        reject_d = 1'b0;
        unique case (state_q)
            ST_INIT0: state_d = ST_INIT1;
            ST_INIT1: state_d = ST_IDLE;
            ST_IDLE: begin
                if (refund_req) begin
                    state_d = ST_CHANGE;
                end else if (select_valid) begin
                    price_d = price;
                    state_d = ST_SEL_CHK;
                end else if (coin_valid) begin
                    if (coin_bad) begin
                        reject_d = 1'b1;
                    end else begin
                        value_d = coin_value(coin_type);
                        state_d = ST_COIN;
                    end
                end
            end
            ST_COIN:    state_d = ST_IDLE;
            // Credit is settled here: the last write landed at least one edge ago.
            ST_SEL_CHK: state_d = ({6'd0, price_q} <= paid) ? ST_DEBIT : ST_DENY;
            ST_DEBIT:   state_d = ST_VEND;
            ST_VEND:    state_d = ST_IDLE;
            ST_DENY:    state_d = ST_IDLE;
            ST_CHANGE:  if (!chg.vld) state_d = ST_IDLE;
            default:    state_d = ST_INIT0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_INIT0;
            price_q  <= 4'd0;
            value_q  <= 4'd0;
            reject_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            price_q  <= price_d;
            value_q  <= value_d;
            reject_q <= reject_d;
        end
    end

    always_comb begin
        op           = OP_CLR;
        rw           = REG_SINK;
        ra           = REG_ZERO;
        rb           = REG_ZERO;
        imm4         = 4'd0;
        vend         = 1'b0;
        deny         = 1'b0;
        change_valid = 1'b0;
        change_type  = COIN_NICKEL;
        busy         = (state_q != ST_IDLE);
        coin_reject  = reject_q;
        case (state_q)
            ST_INIT0: rw = REG_ZERO;
            ST_INIT1: rw = REG_CREDIT;
            ST_COIN: begin
                op   = OP_ADDI;
                ra   = REG_CREDIT;
                rw   = REG_CREDIT;
                imm4 = value_q;
            end
            ST_DEBIT: begin
                op   = OP_SUBI;
                ra   = REG_CREDIT;
                rw   = REG_CREDIT;
                imm4 = price_q;
            end
            ST_VEND: vend = 1'b1;
            ST_DENY: deny = 1'b1;
            ST_CHANGE: begin
                if (chg.vld) begin
                    op           = OP_SUBI;
                    ra           = REG_CREDIT;
                    rw           = REG_CREDIT;
                    imm4         = chg.amt;
                    change_valid = 1'b1;
                    change_type  = chg.coin;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: doc/vend_sequencer.md
# vend_sequencer

- Controller that sequences the vending-machine `calculator` (regfile + ALU) and is the only driver of its `op`, `rw`, `ra`, `rb` and `imm4` inputs.
- Turns coin, selection and refund events into one-cycle micro-ops; compares the `paid` readback against the item price; emits vend, deny and change-coin pulses.
- Sits between the front-panel/coin-mech event logic and `calculator`.

## Interface
- `MAX_CREDIT`, default 200: credit ceiling, in 5-cent units.
- `clk  in  1`: single system clock; all state changes on its rising edge.
- `rst_n  in  1`: reset, asynchronous, active-low.
- `coin_valid  in  1`: 1-cycle pulse, coin inserted.
- `coin_type  in  2`: 00 nickel (1), 01 dime (2), 10 quarter (5), 11 invalid.
- `select_valid  in  1`: 1-cycle pulse, item selected.
- `price  in  4`: item price, 5-cent units; sampled with `select_valid`.
- `refund_req  in  1`: 1-cycle pulse, return all credit.
- `paid  in  10`: calculator r4 readback (credit).
- `op  out  3`, `rw  out  4`, `ra  out  4`, `rb  out  4`, `imm4  out  4`: micro-op to calculator.
- `busy  out  1`: high in every state except IDLE.
- `vend  out  1`: 1-cycle dispense pulse.
- `deny  out  1`: 1-cycle insufficient-credit pulse.
- `coin_reject  out  1`: 1-cycle pulse, coin refused.
- `change_valid  out  1`, `change_type  out  2`: one returned coin per pulse; encoding as `coin_type`.

## Operation
- Calculator register use: r0 = zero, r4 = credit, r15 = sink.
- NOP = `op`=OP_CLR, `rw`=15, `ra`=`rb`=`imm4`=0. NOP is driven in every state not listed below.
- Op codes:
  - OP_CLR = 0: y = 0.
  - OP_ADDI = 1: y = a + imm4.
  - OP_SUBI = 2: y = a − imm4.
  - OP_SUB = 3: y = a − b.
- State machine:
  - INIT0: OP_CLR, rw=0 → INIT1.
  - INIT1: OP_CLR, rw=4 → IDLE.
  - IDLE: busy=0. Priority is refund_req > select_valid > coin_valid.
    - refund_req → CHANGE.
    - select_valid: latch price → SEL_CHK.
    - coin_valid with type 11 → coin_reject, stay in IDLE.
    - coin_valid where paid + value > MAX_CREDIT → coin_reject, stay in IDLE.
    - Otherwise coin_valid: latch value → COIN.
  - COIN: OP_ADDI, ra=4, rw=4, imm4 = value → IDLE.
  - SEL_CHK: no write.
    - paid ≥ price_q → DEBIT.
    - Otherwise → DENY.
    - price_q = 0 always goes to DEBIT (free vend).
  - DEBIT: OP_SUBI, ra=4, rw=4, imm4 = price_q → VEND.
  - VEND: vend=1 → IDLE.
  - DENY: deny=1 → IDLE.
  - CHANGE: one coin per cycle, greedy:
    - paid ≥ 5: OP_SUBI imm4=5, change quarter.
    - else paid ≥ 2: OP_SUBI imm4=2, change dime.
    - else paid = 1: OP_SUBI imm4=1, change nickel.
    - paid = 0: NOP, no change pulse → IDLE.
    - Every SUBI in CHANGE uses ra=4, rw=4.
- Events arriving while busy=1 are dropped; the upstream source must hold off while busy.
- Unsigned 10-bit credit arithmetic; it never underflows because every subtraction is guarded by a compare.

## Timing
- Reset values: state INIT0; busy=1; vend, deny, coin_reject, change_valid = 0; change_type = 00; micro-op outputs = INIT0 values.
- The regfile has no reset. INIT0/INIT1 clear it in 2 cycles after rst_n deasserts.
- Assertion of rst_n mid-operation, including mid-CHANGE, aborts immediately. Credit is discarded by INIT.
- Micro-op outputs and pulses are Moore-decoded from the state register and price_q/value_q registers. `coin_reject` is a 1-cycle pulse in the cycle after the rejected coin.
- Write timing: the micro-op is issued in a state and written at that state's closing edge, so `paid` reflects it in the next cycle.
- Latency from event edge to IDLE:
  - Coin: 2 cycles.
  - Vend: 4 cycles.
  - Deny: 3 cycles.
  - Refund: N+2 cycles, N = coins returned.
- The compare in SEL_CHK is always made on settled credit.

## Structure
- `vend_pkg` holds:
  - OP_* codes.
  - Register indices REG_ZERO=0, REG_CREDIT=4, REG_SINK=15.
  - Coin encodings and coin values.
  - State enum.
- Single module with no sub-module. The greedy change selector is one combinational function in the package.

## Test plan
- Reset release: micro-ops OP_CLR to rw=0 then rw=4, then busy falls at cycle 2; paid=0.
- Insert quarter, dime, nickel → paid = 8; each coin leaves busy high for exactly 1 cycle.
- paid=8, select with price=6 → one SUBI 6, vend pulse, paid=2. paid=2, price=3 → deny pulse, paid unchanged.
- paid=13, refund → change sequence quarter, quarter, dime, nickel, then idle with paid=0; a refund at paid=0 gives no pulses.
- MAX_CREDIT=10, paid=8, quarter → coin_reject, paid=8. Coin type 11 → coin_reject.
- Refund and coin in the same cycle → refund wins, coin dropped. Coin during busy → ignored. rst_n pulsed mid-CHANGE → INIT sequence, paid=0.
